deck_shuffle_ctrl: RTL
======================

# deck_shuffle_ctrl

Sequences an in-place Fisher-Yates shuffle of the card deck held in the single-port deck memory, driven by a free-running LFSR. The block runs after the deck loader has filled the memory and before the card-draw logic starts dealing. While it shuffles, it owns the memory port. The top level muxes the deck memory address, write-enable and write-data onto this block whenever `shuffle_busy` is high.

## Interface
- `DECK_SIZE`, 52: number of cards, stored at addresses 0..DECK_SIZE-1; legal range 2..64.
- `ADDR_W`, 6: deck memory address width.
- `DATA_W`, 7: deck memory word width.
- `LFSR_SEED`, 16'hACE1: LFSR reset value; a value of 0 is replaced by 16'hACE1.
- `clk` in 1: single clock; all state changes on the rising edge.
- `rst` in 1: synchronous, active-low reset.
- `shuffle_req` in 1: start request; sampled only in IDLE.
- `shuffle_busy` out 1: high in every state except IDLE; selects this block as the memory master.
- `shuffle_done` out 1: one-cycle pulse when the shuffle completes.
- `mem_addr` out ADDR_W: deck memory address.
- `mem_wen` out 1: deck memory write enable.
- `mem_wdata` out DATA_W: deck memory write data.
- `mem_rdata` in DATA_W: deck memory read data, valid the cycle after its address was presented (1-cycle latency).

## Operation
- LFSR
  - 16-bit Fibonacci, polynomial x^16+x^14+x^13+x^11+1.
  - Advances every cycle, including IDLE, so player timing adds entropy.
  - Candidate index `r = lfsr[5:0]`.
- Index register `i`, ADDR_W bits:
  - Loaded with DECK_SIZE-1 on an accepted request.
  - Decremented after each swap.
- State machine:
  - IDLE: if `shuffle_req`=1 → PICK, `i`←DECK_SIZE-1.
  - PICK: if `r` ≤ `i`, `j`←`r` → RD_I. Otherwise stay in PICK (rejection sampling; the LFSR has advanced by the next cycle).
  - RD_I: `mem_addr`=`i` → RD_J.
  - RD_J: `mem_addr`=`j`; `card_i`←`mem_rdata` → WAIT.
  - WAIT: `card_j`←`mem_rdata` → WR_I.
  - WR_I: `mem_addr`=`i`, `mem_wdata`=`card_j`, `mem_wen`=1 → WR_J.
  - WR_J: `mem_addr`=`j`, `mem_wdata`=`card_i`, `mem_wen`=1. If `i`==1 → DONE; else `i`←`i`-1 → PICK.
  - DONE: `shuffle_done`=1 → IDLE.
- `j`==`i` is legal: the swap still executes and writes the same word back.
- Outputs are decoded from registered state only; there is no combinational path from input to output.
- In IDLE and DONE: `mem_addr`=0, `mem_wen`=0, `mem_wdata`=0.
- `shuffle_req` is ignored outside IDLE; a request asserted during DONE is lost.

## Timing
- Reset values (`rst`=0 at an edge): state=IDLE, `shuffle_busy`=0, `shuffle_done`=0, `mem_wen`=0, `mem_addr`=0, `mem_wdata`=0, `i`=0, `j`=0, `lfsr`=LFSR_SEED.
- Request latency: `shuffle_req` high at edge N → `shuffle_busy` high from cycle N+1.
- Each swap costs 6 cycles plus 1 cycle per rejection.
- Minimum total for a shuffle: 6×(DECK_SIZE-1)+1 cycles (307 for 52 cards).
- `shuffle_busy` falls on the cycle after DONE.
- Reset mid-operation forces IDLE on the next edge; no write occurs after that edge.
- If reset lands between WR_I and WR_J, the deck holds one duplicated card. The top level must reload the deck via the loader after any reset.

## Configuration
- `DECK_SHUFFLE_FIXED_SEED_EN` defined:
  - The LFSR reloads LFSR_SEED on the edge a request is accepted.
  - Every shuffle of identical deck contents yields an identical permutation, for debug and reproducible deals.
- Not defined:
  - The LFSR is seeded only by reset and runs freely.
  - The permutation depends on the cycle at which `shuffle_req` arrives.

## Test plan
- Reset: hold `rst`=0 for 2 cycles with `shuffle_req`=1 → `shuffle_busy`=0, `shuffle_done`=0, `mem_wen`=0, `mem_addr`=0 throughout, and no state change.
- Full shuffle: preload mem[k]=k for k=0..51, pulse `shuffle_req` → exactly one `shuffle_done` pulse ≥307 cycles later; final memory is a permutation of 0..51; writes occur only in adjacent WR_I/WR_J pairs.
- Determinism (macro defined): preload 0..51, shuffle, record the result; reload 0..51 and shuffle again at a different cycle → identical permutation. Without the macro, the two results differ.
- Busy-ignore: pulse `shuffle_req` 10 and 200 cycles after the first accepted request → only one `shuffle_done`; `i` is never reloaded mid-run.
- Reset mid-shuffle: assert `rst`=0 at cycle 100 of a shuffle → IDLE next edge, `shuffle_busy`=0, `mem_wen`=0 on every following cycle.
- DECK_SIZE=2 with mem = {5, 9} → exactly one swap; final contents {5, 9} or {9, 5}; `shuffle_done` exactly 1 cycle after WR_J.

Source files
------------

// File: rtl/deck_shuffle_ctrl.sv
// In-place Fisher-Yates shuffle sequencer for the single-port deck memory, driven by a free-running LFSR.
// Optional build macro DECK_SHUFFLE_FIXED_SEED_EN reloads the LFSR seed on every accepted request.
module deck_shuffle_ctrl #(
  parameter int unsigned DECK_SIZE = 52,
  parameter int unsigned ADDR_W    = 6,
  parameter int unsigned DATA_W    = 7,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              shuffle_req,
  output logic              shuffle_busy,
  output logic              shuffle_done,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_wen,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int unsigned R_W   = 6;
  localparam int unsigned CMP_W = (ADDR_W > R_W) ? ADDR_W : R_W;
  localparam logic [15:0] SEED_EFF = (LFSR_SEED == 16'h0000) ? 16'hACE1 : LFSR_SEED;
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DECK_SIZE - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_PICK, S_RD_I, S_RD_J, S_WAIT, S_WR_I, S_WR_J, S_DONE
  } state_t;

  state_t            state_q, state_d;
  logic [15:0]       lfsr_q, lfsr_d, lfsr_step;
  logic [ADDR_W-1:0] i_q, i_d, j_q, j_d;
  logic [DATA_W-1:0] card_i_q, card_i_d;
  logic              busy_d, done_d, wen_d;
  logic [ADDR_W-1:0] addr_d;
  logic [DATA_W-1:0] wdata_d;
  logic [R_W-1:0]    r;
  logic              fit;

  // Fibonacci LFSR, taps 16,14,13,11 (right-shifting form)
  assign lfsr_step = {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};
  assign r         = lfsr_q[R_W-1:0];
  assign fit       = CMP_W'(r) <= CMP_W'(i_q);

  // Outputs are registered from the next-state decode so they line up with the state they belong to.
  // The mem_wdata register doubles as card_j: it captures the j read for the WR_I write.
  always_comb begin
    state_d  = state_q;
    lfsr_d   = lfsr_step;
    i_d      = i_q;
    j_d      = j_q;
    card_i_d = card_i_q;
    addr_d   = '0;
    wen_d    = 1'b0;
    wdata_d  = '0;
    case (state_q)
      S_IDLE: begin
        if (shuffle_req) begin
          state_d = S_PICK;
          i_d     = LAST_IDX;
`ifdef DECK_SHUFFLE_FIXED_SEED_EN
          lfsr_d  = SEED_EFF;
`endif
        end
      end
      S_PICK: begin
        // rejection sampling: out-of-range candidates just wait for the next LFSR value
        if (fit) begin
          j_d     = ADDR_W'(r);
          state_d = S_RD_I;
          addr_d  = i_q;
        end
      end
      S_RD_I: begin
        state_d = S_RD_J;
        addr_d  = j_q;
      end
      S_RD_J: begin
        card_i_d = mem_rdata;
        state_d  = S_WAIT;
      end
      S_WAIT: begin
        state_d = S_WR_I;
        addr_d  = i_q;
        wdata_d = mem_rdata;
        wen_d   = 1'b1;
      end
      S_WR_I: begin
        state_d = S_WR_J;
        addr_d  = j_q;
        wdata_d = card_i_q;
        wen_d   = 1'b1;
      end
      S_WR_J: begin
        if (i_q == ADDR_W'(1)) begin
          state_d = S_DONE;
        end else begin
          i_d     = i_q - ADDR_W'(1);
          state_d = S_PICK;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      lfsr_q       <= SEED_EFF;
      i_q          <= '0;
      j_q          <= '0;
      card_i_q     <= '0;
      shuffle_busy <= 1'b0;
      shuffle_done <= 1'b0;
      mem_addr     <= '0;
      mem_wen      <= 1'b0;
      mem_wdata    <= '0;
    end else begin
      state_q      <= state_d;
      lfsr_q       <= lfsr_d;
      i_q          <= i_d;
      j_q          <= j_d;
      card_i_q     <= card_i_d;
      shuffle_busy <= busy_d;
      shuffle_done <= done_d;
      mem_addr     <= addr_d;
      mem_wen      <= wen_d;
      mem_wdata    <= wdata_d;
    end
  end

endmodule
